// File: rtl/i2s_master_clkgen.sv
// rtl/i2s_master_clkgen.sv - I2S bit/word clock generator with a 1-deep sample pair buffer.
// Optional I2S_HOLD_LAST_EN: repeat the last pair on underrun instead of muting.
module i2s_master_clkgen #(
  parameter int PDATA_WIDTH = 32,
  parameter int SCLK_DIV    = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  output logic                   sclk_out,
  output logic                   lrck_out,
  output logic [PDATA_WIDTH-1:0] pldata_out,
  output logic [PDATA_WIDTH-1:0] prdata_out,
  input  logic                   s_valid_in,
  output logic                   s_ready_out,
  input  logic [PDATA_WIDTH-1:0] s_ldata_in,
  input  logic [PDATA_WIDTH-1:0] s_rdata_in,
  output logic                   underrun_out
);

  localparam int DCW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BCW = $clog2(2 * PDATA_WIDTH);

  logic [DCW-1:0]         div_cnt;
  logic [BCW-1:0]         bit_cnt;
  logic [BCW-1:0]         bit_nxt;
  logic                   pend_full;
  logic [PDATA_WIDTH-1:0] pend_l;
  logic [PDATA_WIDTH-1:0] pend_r;
  logic [PDATA_WIDTH-1:0] prdata_nxt;

  logic div_wrap;
  logic sclk_fall;
  logic lrck_nxt;
  logic exch;
  logic frame_wrap;
  logic accept;

  assign div_wrap   = (div_cnt == DCW'(SCLK_DIV - 1));
  assign sclk_fall  = div_wrap && sclk_out;
  assign bit_nxt    = (bit_cnt == BCW'(2 * PDATA_WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
  assign lrck_nxt   = (bit_nxt >= BCW'(PDATA_WIDTH));
  // Exchange and wrap coincide with the LRCK edges, which only move on an SCLK fall.
  assign exch       = sclk_fall && !lrck_out && lrck_nxt;
  assign frame_wrap = sclk_fall && lrck_out && !lrck_nxt;
  assign accept     = s_valid_in && !pend_full;

  assign s_ready_out = !pend_full;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_cnt      <= '0;
      sclk_out     <= 1'b0;
      bit_cnt      <= '0;
      lrck_out     <= 1'b0;
      pend_full    <= 1'b0;
      pend_l       <= '0;
      pend_r       <= '0;
      prdata_nxt   <= '0;
      pldata_out   <= '0;
      prdata_out   <= '0;
      underrun_out <= 1'b0;
    end else begin
      underrun_out <= 1'b0;

      if (div_wrap) begin
        div_cnt  <= '0;
        sclk_out <= !sclk_out;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (sclk_fall) begin
        bit_cnt  <= bit_nxt;
        lrck_out <= lrck_nxt;
      end

      // Left is loaded one fall after LRCK falls, so updating it at the rise is safe.
      if (exch) begin
        if (pend_full) begin
          pldata_out <= pend_l;
          prdata_nxt <= pend_r;
          pend_full  <= 1'b0;
        end else begin
          underrun_out <= 1'b1;
`ifdef I2S_HOLD_LAST_EN
          pldata_out <= pldata_out;
          prdata_nxt <= prdata_nxt;
`else
          pldata_out <= '0;
          prdata_nxt <= '0;
`endif
        end
      end

      // Right is staged until the wrap so it stays stable through its own load.
      if (frame_wrap) begin
        prdata_out <= prdata_nxt;
      end

      // s_ready_out is low whenever exch consumes, so these never collide.
      if (accept) begin
        pend_l    <= s_ldata_in;
        pend_r    <= s_rdata_in;
        pend_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_master_clkgen.sv
// tb/tb_i2s_master_clkgen.sv - randomized bench for i2s_master_clkgen against a frame-level model.
// Build with +define+I2S_HOLD_LAST_EN to check the hold-last variant.
module tb_i2s_master_clkgen;

  localparam int PW    = 16;
  localparam int DIV   = 2;
  localparam int HALF  = 2 * DIV * PW;
  localparam int FRAME = 2 * HALF;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          sclk_out;
  logic          lrck_out;
  logic [PW-1:0] pldata_out;
  logic [PW-1:0] prdata_out;
  logic          s_valid_in = 1'b0;
  logic          s_ready_out;
  logic [PW-1:0] s_ldata_in = '0;
  logic [PW-1:0] s_rdata_in = '0;
  logic          underrun_out;

  always #5 clk_in = ~clk_in;

  i2s_master_clkgen #(.PDATA_WIDTH(PW), .SCLK_DIV(DIV)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .sclk_out    (sclk_out),
    .lrck_out    (lrck_out),
    .pldata_out  (pldata_out),
    .prdata_out  (prdata_out),
    .s_valid_in  (s_valid_in),
    .s_ready_out (s_ready_out),
    .s_ldata_in  (s_ldata_in),
    .s_rdata_in  (s_rdata_in),
    .underrun_out(underrun_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: clocks are pure functions of the edge count; data is a queue of pairs.
  int          n = 0;
  int          ph = 0;
  logic [31:0] src_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] nxt = '0;
  logic [31:0] cur = '0;
  bit          exp_und = 1'b0;
  bit          present = 1'b0;
  bit          gappy = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (edge %0d)", tag, act, exp, n);
    end
  endtask

  task automatic model_edge();
    bit rdy;
    n++;
    ph = n % FRAME;
    exp_und = 1'b0;
    rdy = (pend_q.size() == 0);
    if (ph == HALF) begin
      if (pend_q.size() > 0) begin
        nxt = pend_q.pop_front();
      end else begin
        exp_und = 1'b1;
`ifndef I2S_HOLD_LAST_EN
        nxt = '0;
`endif
      end
    end
    if (s_valid_in && rdy) begin
      pend_q.push_back({s_ldata_in, s_rdata_in});
      void'(src_q.pop_front());
      present = 1'b0;
    end
    if (ph == 0) cur = nxt;
  endtask

  task automatic check_cycle();
    check_eq("sclk", 32'(sclk_out), 32'((n / DIV) % 2));
    check_eq("lrck", 32'(lrck_out), 32'((n / HALF) % 2));
    check_eq("ready", 32'(s_ready_out), 32'(pend_q.size() == 0));
    check_eq("underrun", 32'(underrun_out), 32'(exp_und));
    if (ph == HALF)     check_eq("ldata_at_rise", 32'(pldata_out), 32'(nxt[31:16]));
    if (ph == 4)        check_eq("ser_load_l", 32'(pldata_out), 32'(cur[31:16]));
    if (ph == HALF + 4) check_eq("ser_load_r", 32'(prdata_out), 32'(cur[15:0]));
  endtask

  task automatic drive();
    if (!present && src_q.size() > 0 && (!gappy || $urandom_range(0, 3) == 0)) present = 1'b1;
    s_valid_in = present;
    if (present) {s_ldata_in, s_rdata_in} = src_q[0];
    else         {s_ldata_in, s_rdata_in} = $urandom();
  endtask

  task automatic step();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_cycle();
    drive();
  endtask

  task automatic run_cycles(input int k);
    repeat (k) step();
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (ph == p) break;
    end
  endtask

  task automatic check_reset(input string pfx);
    check_eq({pfx, "_sclk"}, 32'(sclk_out), 32'd0);
    check_eq({pfx, "_lrck"}, 32'(lrck_out), 32'd0);
    check_eq({pfx, "_pldata"}, 32'(pldata_out), 32'd0);
    check_eq({pfx, "_prdata"}, 32'(prdata_out), 32'd0);
    check_eq({pfx, "_underrun"}, 32'(underrun_out), 32'd0);
    check_eq({pfx, "_ready"}, 32'(s_ready_out), 32'd1);
  endtask

  task automatic model_reset();
    src_q.delete();
    pend_q.delete();
    nxt = '0;
    cur = '0;
    n = 0;
    ph = 0;
    exp_und = 1'b0;
    present = 1'b0;
    s_valid_in = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    check_reset("rst0");
    rst_in = 1'b0;

    // Directed stream followed by back-to-back random pairs with valid held high.
    src_q.push_back(32'hA5A5_1234);
    src_q.push_back(32'h0F0F_FFFF);
    for (int i = 0; i < 6; i++) src_q.push_back($urandom());
    drive();
    run_cycles(9 * FRAME);

    // One pair then starvation.
    src_q.push_back(32'h7FFF_8000);
    drive();
    run_cycles(5 * FRAME);

    // Pair presented exactly at the exchange edge with the buffer empty.
    wait_phase(HALF - 1);
    src_q.push_back($urandom());
    drive();
    run_cycles(3 * FRAME);

    // Sparse random traffic with random valid gaps.
    gappy = 1'b1;
    for (int f = 0; f < 10; f++) begin
      if ($urandom_range(0, 1) == 1) src_q.push_back($urandom());
      if ($urandom_range(0, 3) == 0) src_q.push_back($urandom());
      run_cycles(FRAME);
    end
    gappy = 1'b0;
    run_cycles(2 * FRAME);

    // Reset in the right half with a pair pending.
    wait_phase(HALF + 2);
    src_q.push_back($urandom());
    drive();
    wait_phase(HALF + 36);
    #2;
    rst_in = 1'b1;
    #1;
    check_reset("rst_mid");
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    src_q.push_back(32'h1357_9BDF);
    drive();
    run_cycles(3 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
